// File: rtl/wb_write_stage_if.sv
// ---------------------------------------------------------------------------
// wb_write_stage_if
//
// Purpose: bundles every bus-level signal of the write-back stage (the two
// producer handshakes, the register file write port, and the decode read
// bypass/hazard port) so the stage and its environment connect through
// a single port.
//
// Modports:
//   slave  - the write-back stage's view (consumes producers, drives the
//            register file write port and the bypass outputs)
//   master - the environment's view (producers, register file read data,
//            decode read addresses)
//
// Signal summary:
//   alu_valid/alu_ready/alu_wa/alu_wd   ALU result channel
//   ld_valid/ld_ready/ld_wa/ld_wd       load return channel
//   wa/wd/we                            register file write port (registered)
//   ra1/ra2, rf_rd1/rf_rd2              decode read addresses, raw file data
//   rd1/rd2                             bypassed read data
//   pend1/pend2                         held-entry hazard flags
// ---------------------------------------------------------------------------
interface wb_write_stage_if #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32
);

  logic              alu_valid;
  logic              alu_ready;
  logic [RWIDTH-1:0] alu_wa;
  logic [DWIDTH-1:0] alu_wd;

  logic              ld_valid;
  logic              ld_ready;
  logic [RWIDTH-1:0] ld_wa;
  logic [DWIDTH-1:0] ld_wd;

  logic [RWIDTH-1:0] wa;
  logic [DWIDTH-1:0] wd;
  logic              we;

  logic [RWIDTH-1:0] ra1;
  logic [RWIDTH-1:0] ra2;
  logic [DWIDTH-1:0] rf_rd1;
  logic [DWIDTH-1:0] rf_rd2;
  logic [DWIDTH-1:0] rd1;
  logic [DWIDTH-1:0] rd2;
  logic              pend1;
  logic              pend2;

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    input  ld_valid, ld_wa, ld_wd,
    input  ra1, ra2, rf_rd1, rf_rd2,
    output alu_ready, ld_ready,
    output wa, wd, we,
    output rd1, rd2, pend1, pend2
  );

  modport master (
    output alu_valid, alu_wa, alu_wd,
    output ld_valid, ld_wa, ld_wd,
    output ra1, ra2, rf_rd1, rf_rd2,
    input  alu_ready, ld_ready,
    input  wa, wd, we,
    input  rd1, rd2, pend1, pend2
  );

endinterface

// File: rtl/wb_write_stage.sv
// ---------------------------------------------------------------------------
// wb_write_stage
//
// Purpose: write-back stage in front of the register file. Merges the ALU
// result channel and the load-return channel onto the file's single write
// port, keeps a one-entry hold register for an ALU result that loses
// arbitration to a load, and gives decode a same-cycle bypass of the write
// in flight plus a stall flag for reads that hit the held entry.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          wb_write_stage_if.slave (producers, write port, bypass)
//   perf_squash  count of squashed ALU results (saturating, 16 bit)
//   perf_stall   count of cycles with alu_valid && !alu_ready (saturating)
//
// Build option:
//   WB_PERF_CNT_EN  when defined the two performance counters are built;
//                   otherwise both counter outputs are tied to 0.
//
// Hold register state:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   HOLD_EMPTY  | no deferred ALU result; alu_ready=1
//   HOLD_FULL   | one ALU result waiting for a load-free cycle; alu_ready=0
// ---------------------------------------------------------------------------
module wb_write_stage #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_write_stage_if.slave     bus,
  output logic [15:0]         perf_squash,
  output logic [15:0]         perf_stall
);

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  localparam logic [RWIDTH-1:0] REG_ZERO = '0;

  hold_state_t       state;
  hold_state_t       state_nxt;
  logic [RWIDTH-1:0] hold_wa;
  logic [DWIDTH-1:0] hold_wd;
  logic [RWIDTH-1:0] hold_wa_nxt;
  logic [DWIDTH-1:0] hold_wd_nxt;

  logic              hold_v;
  logic              alu_acc;

  logic [RWIDTH-1:0] wr_wa;
  logic [DWIDTH-1:0] wr_wd;
  logic              wr_en;

  logic              squash_evt;
  logic              stall_evt;

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  assign hold_v        = (state == HOLD_FULL);
  assign bus.ld_ready  = 1'b1;
  assign bus.alu_ready = !hold_v;
  assign alu_acc       = bus.alu_valid && bus.alu_ready;
  assign stall_evt     = bus.alu_valid && !bus.alu_ready;

  // -------------------------------------------------------------------------
  // Hold register state and write-port pipeline register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD_EMPTY;
      hold_wa <= '0;
      hold_wd <= '0;
      bus.wa  <= '0;
      bus.wd  <= '0;
      bus.we  <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold_wa <= hold_wa_nxt;
      hold_wd <= hold_wd_nxt;
      bus.wa  <= wr_wa;
      bus.wd  <= wr_wd;
      bus.we  <= wr_en;
    end
  end

  // -------------------------------------------------------------------------
  // Source selection: load, then held ALU entry, then direct ALU result.
  // A direct ALU accept is only possible while the hold is empty, so the
  // held and direct ALU sources never compete.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    hold_wa_nxt = hold_wa;
    hold_wd_nxt = hold_wd;
    wr_wa       = bus.wa;
    wr_wd       = bus.wd;
    wr_en       = 1'b0;
    squash_evt  = 1'b0;

    case (state)
      HOLD_EMPTY: begin
        if (bus.ld_valid) begin
          wr_wa = bus.ld_wa;
          wr_wd = bus.ld_wd;
          wr_en = (bus.ld_wa != REG_ZERO);
          if (alu_acc) begin
            if (bus.alu_wa == bus.ld_wa) begin
              // The load is younger, so the ALU value is already stale.
              squash_evt = 1'b1;
            end else if (bus.alu_wa != REG_ZERO) begin
              state_nxt   = HOLD_FULL;
              hold_wa_nxt = bus.alu_wa;
              hold_wd_nxt = bus.alu_wd;
            end
          end
        end else if (alu_acc) begin
          wr_wa = bus.alu_wa;
          wr_wd = bus.alu_wd;
          wr_en = (bus.alu_wa != REG_ZERO);
        end
      end

      HOLD_FULL: begin
        if (bus.ld_valid) begin
          wr_wa = bus.ld_wa;
          wr_wd = bus.ld_wd;
          wr_en = (bus.ld_wa != REG_ZERO);
          // hold_wa is never zero, so a load to register 0 cannot match.
          if (bus.ld_wa == hold_wa) begin
            state_nxt  = HOLD_EMPTY;
            squash_evt = 1'b1;
          end
        end else begin
          wr_wa     = hold_wa;
          wr_wd     = hold_wd;
          wr_en     = 1'b1;
          state_nxt = HOLD_EMPTY;
        end
      end

      default: begin
        state_nxt = HOLD_EMPTY;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Decode bypass and hazard flags. Only the write already on the file port
  // is forwarded; a read of the held entry stalls decode instead.
  // -------------------------------------------------------------------------
  assign bus.rd1 = (bus.we && (bus.wa == bus.ra1) && (bus.ra1 != REG_ZERO))
                   ? bus.wd : bus.rf_rd1;
  assign bus.rd2 = (bus.we && (bus.wa == bus.ra2) && (bus.ra2 != REG_ZERO))
                   ? bus.wd : bus.rf_rd2;

  assign bus.pend1 = hold_v && (hold_wa == bus.ra1) && (bus.ra1 != REG_ZERO);
  assign bus.pend2 = hold_v && (hold_wa == bus.ra2) && (bus.ra2 != REG_ZERO);

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_squash <= '0;
      perf_stall  <= '0;
    end else begin
      if (squash_evt && (perf_squash != 16'hFFFF)) begin
        perf_squash <= perf_squash + 16'd1;
      end
      if (stall_evt && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = squash_evt ^ stall_evt;
  assign perf_squash = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_wb_write_stage.sv
module tb_wb_write_stage;

  localparam int RW = 6;
  localparam int DW = 32;

  logic        clk;
  logic        rst_n;
  logic [15:0] perf_squash;
  logic [15:0] perf_stall;

  int checks = 0;
  int errors = 0;

  logic [RW+DW-1:0] exp_q[$];

  wb_write_stage_if #(.RWIDTH(RW), .DWIDTH(DW)) bus ();

  wb_write_stage #(.RWIDTH(RW), .DWIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .perf_squash (perf_squash),
    .perf_stall  (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [RW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard monitor: every register file write must match the oldest
  // expected write, in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=wa %0d wd %h required=no write", bus.wa, bus.wd);
      end else begin
        logic [RW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({bus.wa, bus.wd} !== e) begin
          errors++;
          $display("FAIL write actual=wa %0d wd %h required=wa %0d wd %h",
                   bus.wa, bus.wd, e[RW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  logic [15:0] exp_squash;
  logic [15:0] exp_stall;

  initial begin
    rst_n         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_wa    = '0;
    bus.alu_wd    = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_wa     = '0;
    bus.ld_wd     = '0;
    bus.ra1       = '0;
    bus.ra2       = '0;
    bus.rf_rd1    = '0;
    bus.rf_rd2    = '0;

    // Reset state
    #2;
    chk("rst_we", {31'd0, bus.we}, 32'd0);
    chk("rst_wa", {26'd0, bus.wa}, 32'd0);
    chk("rst_wd", bus.wd, 32'd0);
    chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    chk("rst_pend1", {31'd0, bus.pend1}, 32'd0);
    chk("rst_perf_squash", {16'd0, perf_squash}, 32'd0);
    #10 rst_n = 1'b1;
    cyc();

    // Lone ALU write with bypass
    bus.alu_valid = 1'b1; bus.alu_wa = 6'd5; bus.alu_wd = 32'h1234;
    expect_wr(6'd5, 32'h1234);
    cyc();
    bus.alu_valid = 1'b0;
    bus.ra1 = 6'd5; bus.rf_rd1 = 32'h0;
    #1;
    chk("lone_we", {31'd0, bus.we}, 32'd1);
    chk("lone_bypass_rd1", bus.rd1, 32'h1234);
    cyc();

    // Same-cycle split: load first, ALU held one cycle
    bus.ld_valid = 1'b1; bus.ld_wa = 6'd3; bus.ld_wd = 32'hAAAA;
    bus.alu_valid = 1'b1; bus.alu_wa = 6'd4; bus.alu_wd = 32'hBBBB;
    expect_wr(6'd3, 32'hAAAA);
    expect_wr(6'd4, 32'hBBBB);
    cyc();
    bus.ld_valid = 1'b0;
    bus.alu_wa = 6'd6; bus.alu_wd = 32'hCCCC;   // stalls while the hold drains
    bus.ra1 = 6'd4; bus.ra2 = 6'd4;
    #1;
    chk("split_alu_ready_low", {31'd0, bus.alu_ready}, 32'd0);
    chk("split_pend1", {31'd0, bus.pend1}, 32'd1);
    chk("split_pend2", {31'd0, bus.pend2}, 32'd1);
    cyc();
    chk("split_alu_ready_back", {31'd0, bus.alu_ready}, 32'd1);
    chk("split_pend1_clear", {31'd0, bus.pend1}, 32'd0);
    chk("split_drain_bypass", bus.rd1, 32'hBBBB);
    expect_wr(6'd6, 32'hCCCC);
    cyc();
    bus.alu_valid = 1'b0;
    bus.ra1 = 6'd7; bus.rf_rd1 = 32'h55;
    bus.ra2 = 6'd6; bus.rf_rd2 = 32'h0;
    #1;
    chk("nomatch_rd1", bus.rd1, 32'h55);
    chk("match_rd2", bus.rd2, 32'hCCCC);
    cyc();

    // Same-cycle collision: load wins, ALU squashed
    bus.ld_valid = 1'b1; bus.ld_wa = 6'd7; bus.ld_wd = 32'h1;
    bus.alu_valid = 1'b1; bus.alu_wa = 6'd7; bus.alu_wd = 32'h2;
    expect_wr(6'd7, 32'h1);
    cyc();
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    chk("collide_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    cyc();

    // Hold squash: held wa=9 cleared by a younger load to 9
    bus.ld_valid = 1'b1; bus.ld_wa = 6'd8; bus.ld_wd = 32'hDDDD;
    bus.alu_valid = 1'b1; bus.alu_wa = 6'd9; bus.alu_wd = 32'h9999;
    expect_wr(6'd8, 32'hDDDD);
    cyc();
    bus.alu_valid = 1'b0;
    bus.ld_wa = 6'd9; bus.ld_wd = 32'hCAFE;
    expect_wr(6'd9, 32'hCAFE);
    chk("hsq_alu_ready_low", {31'd0, bus.alu_ready}, 32'd0);
    cyc();
    bus.ld_valid = 1'b0;
    bus.ra1 = 6'd9;
    #1;
    chk("hsq_alu_ready_back", {31'd0, bus.alu_ready}, 32'd1);
    chk("hsq_pend1", {31'd0, bus.pend1}, 32'd0);
    cyc();

    // Register zero: handshakes complete, no write
    bus.alu_valid = 1'b1; bus.alu_wa = 6'd0; bus.alu_wd = 32'hFFFF_FFFF;
    chk("r0_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    cyc();
    bus.alu_valid = 1'b0;
    bus.ra1 = 6'd0; bus.rf_rd1 = 32'h77;
    #1;
    chk("r0_alu_we", {31'd0, bus.we}, 32'd0);
    chk("r0_rd1", bus.rd1, 32'h77);
    bus.ld_valid = 1'b1; bus.ld_wa = 6'd0; bus.ld_wd = 32'h5555;
    cyc();
    bus.ld_valid = 1'b0;
    chk("r0_ld_we", {31'd0, bus.we}, 32'd0);
    chk("r0_pend_never", {31'd0, bus.pend1}, 32'd0);

`ifdef WB_PERF_CNT_EN
    exp_squash = 16'd2;
    exp_stall  = 16'd1;
`else
    exp_squash = 16'd0;
    exp_stall  = 16'd0;
`endif
    chk("perf_squash", {16'd0, perf_squash}, {16'd0, exp_squash});
    chk("perf_stall", {16'd0, perf_stall}, {16'd0, exp_stall});
    cyc();

    // Reset mid-hold: held entry to 11 must never be written
    bus.ld_valid = 1'b1; bus.ld_wa = 6'd10; bus.ld_wd = 32'h1010;
    bus.alu_valid = 1'b1; bus.alu_wa = 6'd11; bus.alu_wd = 32'h1111;
    expect_wr(6'd10, 32'h1010);
    cyc();
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    bus.ra1 = 6'd11; bus.ra2 = 6'd11;
    #1;
    chk("mid_hold_pend1", {31'd0, bus.pend1}, 32'd1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, bus.we}, 32'd0);
    chk("mid_rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("mid_rst_pend1", {31'd0, bus.pend1}, 32'd0);
    chk("mid_rst_pend2", {31'd0, bus.pend2}, 32'd0);
    chk("mid_rst_perf_squash", {16'd0, perf_squash}, 32'd0);
    #7;
    rst_n = 1'b1;
    repeat (4) cyc();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_stage.md
Name: wb_write_stage

Overview:
- Write-back stage that sits directly upstream of the 32-bit register file. It drives the file's write address, write data and write enable.
- Merges two result producers onto the file's single write port: the ALU result channel and the load-return channel. Each is a valid/ready handshake.
- Provides same-cycle read bypass for the decode stage, plus a pending-hazard flag for each decode read address.

Parameters:
RWIDTH, 6, register address width (2**RWIDTH registers)
DWIDTH, 32, data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result valid
alu_ready  out  1  stage accepts ALU result
alu_wa  in  RWIDTH  ALU destination register
alu_wd  in  DWIDTH  ALU result
ld_valid  in  1  load return valid
ld_ready  out  1  stage accepts load return
ld_wa  in  RWIDTH  load destination register
ld_wd  in  DWIDTH  load data
wa  out  RWIDTH  register file write address (registered)
wd  out  DWIDTH  register file write data (registered)
we  out  1  register file write enable (registered)
ra1  in  RWIDTH  decode read address 1
ra2  in  RWIDTH  decode read address 2
rf_rd1  in  DWIDTH  raw register file read data 1
rf_rd2  in  DWIDTH  raw register file read data 2
rd1  out  DWIDTH  bypassed read data 1
rd2  out  DWIDTH  bypassed read data 2
pend1  out  1  ra1 matches held ALU entry; decode must stall
pend2  out  1  ra2 matches held ALU entry; decode must stall
perf_squash  out  16  squashed ALU results (optional feature)
perf_stall  out  16  cycles with alu_ready low (optional feature)

Behaviour:
- Reset, asynchronous while rst_n is low:
  - we=0, wa=0, wd=0.
  - Hold register empty: hold_v=0, hold_wa=0, hold_wd=0.
  - perf counters = 0.
- Reset mid-operation discards the held entry and any in-flight write.
- ld_ready is constant 1; loads are never back-pressured.
- alu_ready = !hold_v.
- Write-source selection each cycle, highest priority first:
  1. Accepted load (ld_valid).
  2. Held ALU entry (hold_v).
  3. Directly accepted ALU result (alu_valid && alu_ready).
- The selected source is registered onto wa/wd/we at the next rising edge.
  - Latency: accepted at edge N, presented on wa/wd/we after edge N, committed in the register file at edge N+1.
  - When no source is selected, we=0; wa and wd hold their previous values.
- ALU result accepted in the same cycle as a load:
  - Different destination registers: ALU result loads into the hold register (hold_v=1).
  - Same destination register: ALU result is discarded (the load is younger) and counts as a squash.
- Held entry when a new load arrives:
  - Load wa equals hold_wa: the held entry is cleared without writing, and counts as a squash.
  - Otherwise the held entry stays and drains on the first cycle with no load.
- Held entry draining in a cycle with alu_valid: alu_ready is 0 that cycle, so nothing new is accepted. alu_ready returns to 1 the cycle after the drain.
- Register 0:
  - A source with destination 0 is accepted (its handshake completes) but produces we=0.
  - An ALU result with destination 0 is never placed in the hold register.
- Bypass (combinational):
  - rd1 = wd if (we && wa==ra1 && ra1!=0); otherwise rf_rd1.
  - rd2 is identical, using ra2 and rf_rd2.
- Pending flags (combinational):
  - pend1 = hold_v && hold_wa==ra1 && ra1!=0.
  - pend2 is identical, using ra2.
  - The held entry is never forwarded; decode stalls instead.
- At most one write per cycle; no result is ever lost except by the squash rules above.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined:
  - perf_squash increments once per squash event (same-cycle same-destination discard, or held-entry clear).
  - perf_stall increments each cycle that alu_valid && !alu_ready.
  - Both counters are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: the counters are not built and both ports are tied to 0.

Test Plan:
- Lone ALU write: alu_valid, alu_wa=5, alu_wd=32'h1234 -> one cycle later we=1, wa=5, wd=32'h1234; that cycle ra1=5 returns rd1=32'h1234 while rf_rd1=0.
- Same-cycle split: load (wa=3, wd=32'hAAAA) with ALU (wa=4, wd=32'hBBBB) -> we=1 for wa=3 then wa=4 on consecutive cycles; alu_ready=0 for exactly one cycle; pend1=1 when ra1=4 during hold.
- Same-cycle collision: load and ALU both wa=7 (load wd=32'h1, ALU wd=32'h2) -> single write wa=7, wd=32'h1; perf_squash=1 when WB_PERF_CNT_EN is defined.
- Hold squash: ALU wa=9 held, then a load with wa=9, wd=32'hCAFE arrives next cycle -> only wa=9, wd=32'hCAFE is written; hold_v cleared; alu_ready=1 the following cycle.
- Register zero: ALU wa=0, wd=32'hFFFF_FFFF -> handshake completes, we stays 0; ra1=0 returns rd1=rf_rd1.
- Reset mid-hold: hold_v=1, then rst_n pulsed low -> we=0 immediately, alu_ready=1, pend1=pend2=0, and the held entry is never written.
